// File: rtl/mem_fifo_pkg.sv
// Shared constants and types for the 16x8 memory-backed FIFO controller.
package mem_fifo_pkg;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    PRIO_POP  = 1'b0,
    PRIO_PUSH = 1'b1
  } prio_t;

endpackage

// File: rtl/mem_fifo_ptr.sv
// Write/read pointers and occupancy counter for the memory-backed FIFO.
module mem_fifo_ptr #(
  parameter int AW = mem_fifo_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_fire,
  input  logic          pop_fire,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointers are exactly AW bits wide so they wrap at the depth for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push_fire};
    rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop_fire};
    count_d  = count_q;
    if (push_fire) begin
      count_d = count_q + 1'b1;
    end else if (pop_fire) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign full   = (count_q == CAP);
  assign empty  = (count_q == '0);

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller over a single-port 16x8 synchronous memory with push/pop round-robin arbitration.
// Define MEM_FIFO_OUT_REG_EN to register out_data/out_valid (read latency 2 instead of 1).
module mem_fifo_ctrl #(
  parameter int DW = mem_fifo_pkg::DW,
  parameter int AW = mem_fifo_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop_req,
  output logic          pop_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          err_underflow,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  import mem_fifo_pkg::*;

  logic          conflict;
  logic          push_fire, pop_fire;
  logic [AW-1:0] wr_ptr, rd_ptr;
  prio_t         prio_q, prio_d;
  logic          err_q, err_d;
  logic          rd_pend_q, rd_pend_d;

  mem_fifo_ptr #(.AW(AW)) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .push_fire (push_fire),
    .pop_fire  (pop_fire),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // The memory does one access per cycle, so a contested cycle serves only the prio side.
  always_comb begin
    conflict   = push_valid & ~full & pop_req & ~empty;
    push_ready = ~full & (~conflict | (prio_q == PRIO_PUSH));
    pop_ready  = ~empty & (~conflict | (prio_q == PRIO_POP));
    push_fire  = push_valid & push_ready;
    pop_fire   = pop_req & pop_ready;

    prio_d = prio_q;
    if (conflict) begin
      prio_d = (prio_q == PRIO_POP) ? PRIO_PUSH : PRIO_POP;
    end

    err_d     = err_q | (pop_req & empty);
    rd_pend_d = pop_fire;

    mem_wr  = push_fire;
    mem_rd  = pop_fire;
    mem_ad  = '0;
    mem_din = '0;
    if (push_fire) begin
      mem_ad  = wr_ptr;
      mem_din = push_data;
    end else if (pop_fire) begin
      mem_ad = rd_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q    <= PRIO_POP;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      err_q     <= err_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign err_underflow = err_q;

`ifdef MEM_FIFO_OUT_REG_EN
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;

  // Capture the memory's registered output one cycle later and hold it between reads.
  always_comb begin
    out_valid_d = rd_pend_q;
    out_data_d  = rd_pend_q ? mem_dout : out_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`else
  assign out_valid = rd_pend_q;
  assign out_data  = mem_dout;
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based FIFO model.
module tb_mem_fifo_ctrl;

`ifdef MEM_FIFO_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push_valid = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       push_ready;
  logic       pop_req = 1'b0;
  logic       pop_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       full, empty;
  logic [4:0] count;
  logic       err_underflow;
  logic       mem_wr, mem_rd;
  logic [3:0] mem_ad;
  logic [7:0] mem_din;
  logic [7:0] mem_dout = 8'h00;

  always #5 clk = ~clk;

  mem_fifo_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .push_valid    (push_valid),
    .push_data     (push_data),
    .push_ready    (push_ready),
    .pop_req       (pop_req),
    .pop_ready     (pop_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .err_underflow (err_underflow),
    .mem_wr        (mem_wr),
    .mem_rd        (mem_rd),
    .mem_ad        (mem_ad),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout)
  );

  // Behavioural 16x8 single-port memory with registered read data.
  logic [7:0] mem_arr [16];
  always @(posedge clk) begin
    if (mem_wr) mem_arr[mem_ad] <= mem_din;
    if (mem_rd) mem_dout <= mem_arr[mem_ad];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] mq[$];
  int         m_wr_addr;
  bit         m_prio_push;
  bit         m_err;
  bit         pipe_v [LAT+1];
  logic [7:0] pipe_d [LAT+1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_wr_addr   = 0;
    m_prio_push = 1'b0;
    m_err       = 1'b0;
    for (int i = 0; i <= LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    push_valid = 1'b0;
    pop_req    = 1'b0;
    push_data  = 8'h00;
    rst        = 1'b1;
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_count", {27'd0, count}, 32'd0);
    check_eq("rst_empty", {31'd0, empty}, 32'd1);
    check_eq("rst_full", {31'd0, full}, 32'd0);
    check_eq("rst_err", {31'd0, err_underflow}, 32'd0);
    check_eq("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check_eq("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("rst_mem_ad", {28'd0, mem_ad}, 32'd0);
    check_eq("rst_mem_din", {24'd0, mem_din}, 32'd0);
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive, check combinational grants/memory drive, then registered outputs.
  task automatic step(input bit pv, input logic [7:0] pd, input bit pr);
    bit         full_m, empty_m, conf, exp_push_rdy, exp_pop_rdy, pf, qf;
    logic [3:0] exp_ad;
    logic [7:0] exp_din, popped;
    @(negedge clk);
    push_valid = pv;
    push_data  = pd;
    pop_req    = pr;
    #1;
    full_m       = (mq.size() == 16);
    empty_m      = (mq.size() == 0);
    conf         = pv && !full_m && pr && !empty_m;
    exp_push_rdy = !full_m && (!conf || m_prio_push);
    exp_pop_rdy  = !empty_m && (!conf || !m_prio_push);
    pf           = pv && exp_push_rdy;
    qf           = pr && exp_pop_rdy;
    exp_ad       = pf ? 4'(m_wr_addr) : (qf ? 4'((m_wr_addr - mq.size()) & 15) : 4'd0);
    exp_din      = pf ? pd : 8'h00;
    check_eq("push_ready", {31'd0, push_ready}, {31'd0, exp_push_rdy});
    check_eq("pop_ready", {31'd0, pop_ready}, {31'd0, exp_pop_rdy});
    check_eq("mem_wr", {31'd0, mem_wr}, {31'd0, pf});
    check_eq("mem_rd", {31'd0, mem_rd}, {31'd0, qf});
    check_eq("mem_ad", {28'd0, mem_ad}, {28'd0, exp_ad});
    check_eq("mem_din", {24'd0, mem_din}, {24'd0, exp_din});

    if (conf) m_prio_push = !m_prio_push;
    if (pr && empty_m) m_err = 1'b1;
    popped = 8'h00;
    if (pf) begin
      mq.push_back(pd);
      m_wr_addr = (m_wr_addr + 1) % 16;
    end
    if (qf) popped = mq.pop_front();
    for (int i = LAT; i >= 2; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[1] = qf;
    pipe_d[1] = popped;
    if (pf) $display("[%0t] push %02h count->%0d", $time, pd, mq.size());
    if (qf) $display("[%0t] pop  %02h count->%0d", $time, popped, mq.size());

    @(posedge clk);
    #1;
    check_eq("count", {27'd0, count}, mq.size());
    check_eq("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
    check_eq("full", {31'd0, full}, {31'd0, mq.size() == 16});
    check_eq("err_underflow", {31'd0, err_underflow}, {31'd0, m_err});
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, pipe_v[LAT]});
    if (pipe_v[LAT]) check_eq("out_data", {24'd0, out_data}, {24'd0, pipe_d[LAT]});
  endtask

  int pv_pct, pr_pct;

  initial begin
    model_clear();
    do_reset();

    // Basic push three, pop three
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    check_eq("basic_count3", {27'd0, count}, 32'd3);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
    for (int i = 0; i < LAT; i++) step(0, 8'h00, 0);

    // Fill to full, 17th push ignored
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
    step(1, 8'h55, 0);
    check_eq("full_count16", {27'd0, count}, 32'd16);

    // Wrap: pop 4, push 4 at addresses 0..3, drain all
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1);
    for (int i = 0; i < LAT; i++) step(0, 8'h00, 0);

    // Contention at count 4: pop, push, pop, push
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'hB0 + 8'(i), 0);
    for (int i = 0; i < 4; i++) step(1, 8'hC0 + 8'(i), 1);
    check_eq("contention_count", {27'd0, count}, 32'd4);
    for (int i = 0; i < 4 + LAT; i++) step(0, 8'h00, 1);

    // Underflow is sticky across later traffic
    do_reset();
    step(0, 8'h00, 1);
    step(1, 8'h5A, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    check_eq("underflow_sticky", {31'd0, err_underflow}, 32'd1);

    // Reset right after a pop abandons the read
    do_reset();
    step(1, 8'h77, 0);
    step(1, 8'h78, 0);
    step(0, 8'h00, 1);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0);

    // Random traffic with shifting fill/drain bias
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      pv_pct = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 30 : 60);
      pr_pct = (blk % 3 == 0) ? 30 : ((blk % 3 == 1) ? 80 : 60);
      for (int i = 0; i < 80; i++) begin
        step($urandom_range(99) < pv_pct, 8'($urandom), $urandom_range(99) < pr_pct);
      end
    end
    for (int i = 0; i < LAT; i++) step(0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_fifo_ctrl.md
Name: mem_fifo_ctrl

Overview:
- Upstream/downstream controller for the team's 16x8 single-port synchronous memory.
- Turns that memory into a 16-deep FIFO.
- Accepts producer pushes (valid/ready) and consumer pop requests, and generates the memory's wr/rd/address/data-in.
- Returns read data from the memory's registered data-out with a valid strobe.
- Arbitrates simultaneous push and pop, because the memory performs only one operation per cycle.

Parameters:
- DW, 8, data width; matches memory data width.
- AW, 4, address width; FIFO depth = 2**AW = 16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- push_valid  in  1  producer has data.
- push_data  in  DW  producer data.
- push_ready  out  1  push accepted this cycle when push_valid is also high.
- pop_req  in  1  consumer requests one word.
- pop_ready  out  1  pop accepted this cycle when pop_req is also high.
- out_valid  out  1  out_data carries a popped word this cycle.
- out_data  out  DW  popped word.
- full  out  1  count == 16.
- empty  out  1  count == 0.
- count  out  AW+1  occupancy, 0..16.
- err_underflow  out  1  sticky; set when pop_req is high while empty.
- mem_wr  out  1  to memory wr.
- mem_rd  out  1  to memory rd.
- mem_ad  out  AW  to memory ad.
- mem_din  out  DW  to memory Datain.
- mem_dout  in  DW  from memory Dataout.

Behaviour:
- Reset (async, immediate):
  - wr_ptr=0, rd_ptr=0, count=0, prio=POP, out_valid=0, err_underflow=0.
  - empty=1, full=0.
  - mem_wr=0, mem_rd=0, mem_ad=0, mem_din=0.
  - Reset mid-operation abandons any in-flight read: no out_valid after reset deassertion.
- Conflict = push_valid & !full & pop_req & !empty.
- Grants:
  - push_ready = !full & (!conflict | prio==PUSH).
  - pop_ready = !empty & (!conflict | prio==POP).
  - push_fire = push_valid & push_ready; pop_fire = pop_req & pop_ready; never both in one cycle.
- prio flips only on a cycle with conflict, and then to the side not served. Round-robin, no starvation.
- Memory drive is combinational from the fire signals:
  - push_fire: mem_wr=1, mem_rd=0, mem_ad=wr_ptr, mem_din=push_data.
  - pop_fire: mem_rd=1, mem_wr=0, mem_ad=rd_ptr.
  - Neither: mem_wr=mem_rd=0, mem_ad=0, mem_din=0.
- Pointers are AW bits and wrap 15->0 naturally. wr_ptr increments on push_fire; rd_ptr increments on pop_fire.
- count: +1 on push_fire, -1 on pop_fire, never both.
- Read latency 1: pop_fire in cycle N → out_valid=1 in cycle N+1, out_data=mem_dout in N+1.
  - out_valid is a registered one-cycle pulse.
  - out_data is meaningful only while out_valid=1, since the memory drives high-Z/stale data on idle cycles.
- Boundaries:
  - Push while full: push_ready=0, no write, count held.
  - Pop while empty: pop_ready=0, no read, err_underflow set and held until rst.
  - Push to an empty FIFO: pop_ready rises the following cycle (count=1). No same-cycle bypass.
  - Back-to-back pops without contention: one word per cycle, out_valid continuous.

Optional Feature:
- Macro MEM_FIFO_OUT_REG_EN.
- Defined:
  - out_data and out_valid are registered from mem_dout; read latency becomes 2 (pop_fire N → out_valid N+2).
  - out_data holds the last popped word until the next out_valid; reset value 0.
- Undefined: latency 1, out_data passes through mem_dout.

Decomposition:
- Package mem_fifo_pkg holds:
  - constants DW=8, AW=4, DEPTH=16;
  - enum prio_t {PRIO_POP=0, PRIO_PUSH=1}.
- One sub-module is natural: mem_fifo_ptr, holding wr_ptr/rd_ptr/count with wrap, full/empty flags and the inc inputs.
- Arbitration and the memory drive stay in the top module.

Test Plan:
- Reset then push 0x11,0x22,0x33 on consecutive cycles → mem_wr pulses at ad=0,1,2; count=3. Pop 3x → out_valid in N+1 with 0x11,0x22,0x33.
- Push 16 words 0x00..0x0F → full=1, push_ready=0. A 17th push is ignored and count stays 16.
- Wrap: fill 16, pop 4, push 0xA0..0xA3 → writes at ad=0..3. Drain gives 0x04..0x0F then 0xA0..0xA3.
- Contention: count=4 and push_valid & pop_req held 4 cycles → grants alternate pop,push,pop,push starting with pop; count ends at 4.
- Pop on empty → pop_ready=0, mem_rd=0, err_underflow=1, and it stays 1 after subsequent traffic.
- Assert rst the cycle after a pop_fire → out_valid=0, count=0, empty=1 immediately; no stale out_valid after release.
